// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Optional feature macro used by this slice: IF_MISALIGN_CHECK_EN.
package if_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4
  } if_state_t;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_pc_reg.sv
// Architectural PC register: redirect, sequential increment and optional word alignment.
// Alignment masking and the misalign pulse exist only when IF_MISALIGN_CHECK_EN is defined.
module if_pc_reg
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  input  logic        inc_i,
  output logic [31:0] pc_o,
  output logic        misalign_o
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] target_s;
  logic        misalign_q, misalign_d;

`ifdef IF_MISALIGN_CHECK_EN
  assign target_s   = align_word(redirect_addr_i);
  assign misalign_d = redirect_i & (redirect_addr_i[1:0] != 2'b00);
`else
  assign target_s   = redirect_addr_i;
  assign misalign_d = 1'b0;
`endif

  // Redirect wins over increment; increment wraps modulo 2^32.
  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = target_s;
    end else if (inc_i) begin
      pc_d = pc_q + PC_STEP;
    end else begin
      pc_d = pc_q;
    end
  end

  // PC and misalign pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc_o       = pc_q;
  assign misalign_o = misalign_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: single-outstanding imem handshake feeding the IF/ID register.
// Build option IF_MISALIGN_CHECK_EN enables redirect alignment and the fetch_misalign pulse.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        mem_freeze,
  input  logic        flush,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_out,
  output logic [31:0] Instruction_out,
  output logic        fetch_busy,
  output logic        fetch_misalign
);

  if_state_t   state_q, state_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] pc_s;
  logic        inc_s;
  logic        consume_s;
  logic        misalign_s;

  if_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk            (clk),
    .rst            (rst),
    .redirect_i     (flush),
    .redirect_addr_i(branch_addr),
    .inc_i          (inc_s),
    .pc_o           (pc_s),
    .misalign_o     (misalign_s)
  );

  assign consume_s = out_valid_q & ~freeze & ~mem_freeze & ~flush;

  // Next state and output buffer; a redirect must still swallow any response already owed to us.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_pc_d    = out_pc_q;
    inc_s       = 1'b0;
    if (flush) begin
      out_valid_d = 1'b0;
      case (state_q)
        REQ:     state_d = imem_ready  ? DRAIN : REQ;
        WAIT:    state_d = imem_rvalid ? REQ   : DRAIN;
        DRAIN:   state_d = imem_rvalid ? REQ   : DRAIN;
        default: state_d = REQ;
      endcase
    end else begin
      case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          if (imem_ready) begin
            state_d = WAIT;
          end else begin
            state_d = REQ;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            out_inst_d  = imem_rdata;
            out_pc_d    = pc_s + PC_STEP;
            out_valid_d = 1'b1;
            inc_s       = 1'b1;
            state_d     = HOLD;
          end else begin
            state_d = WAIT;
          end
        end
        HOLD: begin
          if (consume_s) begin
            out_valid_d = 1'b0;
            state_d     = REQ;
          end else begin
            state_d = HOLD;
          end
        end
        DRAIN: begin
          if (imem_rvalid) begin
            state_d = REQ;
          end else begin
            state_d = DRAIN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output-buffer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_inst_q  <= INSTR_NOP;
      out_pc_q    <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_pc_q    <= out_pc_d;
    end
  end

  assign imem_req        = (state_q == REQ);
  assign imem_addr       = imem_req ? pc_s : 32'h0000_0000;
  assign PC_out          = out_valid_q ? out_pc_q : 32'h0000_0000;
  assign Instruction_out = out_valid_q ? out_inst_q : INSTR_NOP;
  assign fetch_busy      = ~out_valid_q;
  assign fetch_misalign  = misalign_s;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: transaction-level model plus directed redirect/stall scenarios.
// Honours IF_MISALIGN_CHECK_EN the same way as the design build.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze, mem_freeze, flush;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] PC_out, Instruction_out;
  logic        fetch_busy, fetch_misalign;

  logic        ready_en;
  int          lat;
  logic        ovr_en;
  logic [31:0] ovr_data;
  int          cnt;
  logic [31:0] pend_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .freeze         (freeze),
    .mem_freeze     (mem_freeze),
    .flush          (flush),
    .branch_addr    (branch_addr),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .PC_out         (PC_out),
    .Instruction_out(Instruction_out),
    .fetch_busy     (fetch_busy),
    .fetch_misalign (fetch_misalign)
  );

  assign imem_ready = ready_en;

  // Memory: answers each accepted request 'lat' cycles later with addr ^ A5A5_0000 (or an override word).
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_rvalid <= 1'b0;
      imem_rdata  <= 32'h0;
      cnt         <= 0;
      pend_data   <= 32'h0;
    end else begin
      imem_rvalid <= 1'b0;
      if (cnt != 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= pend_data;
        end
      end
      if (imem_req && imem_ready) begin
        if (lat <= 1) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= ovr_en ? ovr_data : (imem_addr ^ 32'hA5A5_0000);
        end else begin
          cnt       <= lat - 1;
          pend_data <= ovr_en ? ovr_data : (imem_addr ^ 32'hA5A5_0000);
        end
      end
    end
  end

  // Model: "requesting", "response owed", "response to discard" and "buffer full" as independent facts.
  typedef struct packed {
    logic        boot;
    logic        req;
    logic        owed;
    logic        drop;
    logic        bv;
    logic [31:0] pc;
    logic [31:0] bpc;
    logic [31:0] binst;
    logic        mis;
  } mdl_t;

  localparam mdl_t MDL_RST = '{boot: 1'b1, req: 1'b0, owed: 1'b0, drop: 1'b0, bv: 1'b0,
                               pc: 32'h0, bpc: 32'h0, binst: 32'h0, mis: 1'b0};

  function automatic mdl_t step(input mdl_t m, input logic fl, input logic [31:0] ba,
                                input logic fz, input logic mfz, input logic rdy,
                                input logic rv, input logic [31:0] rd);
    mdl_t        n;
    logic        acc;
    logic [31:0] tgt;
    n     = m;
    acc   = m.req & rdy;
    tgt   = ba;
    n.mis = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
    tgt   = ba & 32'hFFFF_FFFC;
    n.mis = fl & (ba[1:0] != 2'b00);
`endif
    if (fl) begin
      n.boot = 1'b0;
      n.pc   = tgt;
      n.bv   = 1'b0;
      if (acc || (m.owed && !rv)) begin
        n.req = 1'b0; n.owed = 1'b1; n.drop = 1'b1;
      end else begin
        n.req = 1'b1; n.owed = 1'b0; n.drop = 1'b0;
      end
    end else begin
      if (m.boot) begin
        n.boot = 1'b0; n.req = 1'b1;
      end
      if (acc) begin
        n.req = 1'b0; n.owed = 1'b1;
      end
      if (m.owed && rv) begin
        n.owed = 1'b0;
        if (m.drop) begin
          n.drop = 1'b0; n.req = 1'b1;
        end else begin
          n.bv = 1'b1; n.binst = rd; n.bpc = m.pc + 32'd4; n.pc = m.pc + 32'd4;
        end
      end
      if (m.bv && !fz && !mfz) begin
        n.bv = 1'b0; n.req = 1'b1;
      end
    end
    return n;
  endfunction

  mdl_t m;

  // Advance the model on the same edges the design sees.
  always @(posedge clk or posedge rst) begin
    if (rst) m <= MDL_RST;
    else     m <= step(m, flush, branch_addr, freeze, mem_freeze, imem_ready, imem_rvalid, imem_rdata);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("m_imem_req", {31'b0, imem_req}, {31'b0, m.req});
      chk("m_imem_addr", imem_addr, m.req ? m.pc : 32'h0);
      chk("m_PC_out", PC_out, m.bv ? m.bpc : 32'h0);
      chk("m_Instruction_out", Instruction_out, m.bv ? m.binst : 32'h0);
      chk("m_fetch_busy", {31'b0, fetch_busy}, {31'b0, ~m.bv});
      chk("m_fetch_misalign", {31'b0, fetch_misalign}, {31'b0, m.mis});
      if (Instruction_out === 32'hDEAD_BEEF) chk("dropped_word_seen", Instruction_out, 32'h0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req"}, {31'b0, imem_req}, 32'd0);
    chk({tag, "_addr"}, imem_addr, 32'h0);
    chk({tag, "_pc"}, PC_out, 32'h0);
    chk({tag, "_inst"}, Instruction_out, 32'h0);
    chk({tag, "_busy"}, {31'b0, fetch_busy}, 32'd1);
    chk({tag, "_mis"}, {31'b0, fetch_misalign}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; mem_freeze = 1'b0; flush = 1'b0; branch_addr = 32'h0;
    ready_en = 1'b1; lat = 1; ovr_en = 1'b0; ovr_data = 32'hDEAD_BEEF;
    tick(2);
    chk_idle_outputs("reset");
    rst = 1'b0;

    // Boot sequence and back-to-back fetch.
    tick(1);
    chk("boot_req", {31'b0, imem_req}, 32'd1);
    chk("boot_addr", imem_addr, 32'h0);
    tick(2);
    chk("first_pc", PC_out, 32'h4);
    chk("first_inst", Instruction_out, 32'hA5A5_0000);
    tick(1);
    chk("second_addr", imem_addr, 32'h4);
    tick(2);
    chk("second_pc", PC_out, 32'h8);
    chk("second_inst", Instruction_out, 32'hA5A5_0004);

    // Hazard freeze while holding.
    freeze = 1'b1;
    tick(5);
    chk("frz_pc", PC_out, 32'h8);
    chk("frz_req", {31'b0, imem_req}, 32'd0);
    freeze = 1'b0;
    tick(1);
    chk("post_frz_addr", imem_addr, 32'h8);

    // Redirect while waiting; the late response must be discarded.
    lat = 3; ovr_en = 1'b1;
    tick(1);
    flush = 1'b1; branch_addr = 32'h100; ovr_en = 1'b0; lat = 1;
    tick(1);
    flush = 1'b0;
    tick(2);
    chk("drain_req", {31'b0, imem_req}, 32'd1);
    chk("drain_addr", imem_addr, 32'h100);

    // Redirect in the same cycle as the response.
    tick(1);
    flush = 1'b1; branch_addr = 32'h40;
    tick(1);
    flush = 1'b0;
    chk("same_cyc_addr", imem_addr, 32'h40);
    chk("same_cyc_inst", Instruction_out, 32'h0);
    tick(2);
    chk("x40_pc", PC_out, 32'h44);
    chk("x40_inst", Instruction_out, 32'hA5A5_0040);

    // Flush outranks freeze.
    freeze = 1'b1; flush = 1'b1; branch_addr = 32'h200;
    tick(1);
    freeze = 1'b0; flush = 1'b0;
    chk("ff_addr", imem_addr, 32'h200);
    chk("ff_busy", {31'b0, fetch_busy}, 32'd1);
    chk("ff_inst", Instruction_out, 32'h0);

    // Misaligned redirect while a request is stalled by the memory.
    ready_en = 1'b0; flush = 1'b1; branch_addr = 32'h103;
    tick(1);
    flush = 1'b0; ready_en = 1'b1;
`ifdef IF_MISALIGN_CHECK_EN
    chk("mis_addr", imem_addr, 32'h100);
    chk("mis_pulse", {31'b0, fetch_misalign}, 32'd1);
`else
    chk("mis_addr", imem_addr, 32'h103);
    chk("mis_pulse", {31'b0, fetch_misalign}, 32'd0);
`endif
    tick(1);
    chk("mis_pulse_end", {31'b0, fetch_misalign}, 32'd0);
    tick(1);
    mem_freeze = 1'b1;
    tick(2);
    mem_freeze = 1'b0;
    tick(3);

    // PC wrap at the top of the address space.
    flush = 1'b1; branch_addr = 32'hFFFF_FFFC;
    tick(1);
    flush = 1'b0;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    tick(2);
    chk("wrap_pc", PC_out, 32'h0);
    chk("wrap_inst", Instruction_out, 32'h5A5A_FFFC);
    chk("wrap_busy", {31'b0, fetch_busy}, 32'd0);
    tick(1);
    chk("wrap_next_addr", imem_addr, 32'h0);

    // Reset in the middle of a transaction.
    tick(1);
    rst = 1'b1;
    #1;
    chk_idle_outputs("midrst");
    tick(2);
    rst = 1'b0;
    tick(1);
    chk("rerun_addr", imem_addr, 32'h0);
    chk("rerun_req", {31'b0, imem_req}, 32'd1);
    tick(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
